// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the multi-channel convolution engine.
// Builds with or without CONV_RELU_EN; the macro itself is consumed in conv_out_stage.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] STRIDE_ONE = 2'd1;
    localparam logic [1:0] STRIDE_TWO = 2'd2;

    // Wide enough that MAX_IN_CH * MAX_KERNEL_DIM^2 full-scale products cannot overflow.
    function automatic int acc_width(input int data_width, input int max_ch, input int max_k);
        return 2 * data_width + $clog2(max_ch * max_k * max_k);
    endfunction

    function automatic logic signed [63:0] sat_to_data(input logic signed [63:0] v,
                                                       input int data_width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/conv_multich_nmcu_if.sv
// Start/busy/done handshake, configuration and buffer views between the NMCU
// controller and the convolution engine.
interface conv_multich_nmcu_if #(
    parameter int MAX_INPUT_DIM  = 15,
    parameter int MAX_KERNEL_DIM = 7,
    parameter int MAX_IN_CH      = 4,
    parameter int DATA_WIDTH     = 16
);
    localparam int DIM_W = $clog2(MAX_INPUT_DIM) + 1;
    localparam int KS_W  = $clog2(MAX_KERNEL_DIM) + 1;
    localparam int CH_W  = $clog2(MAX_IN_CH) + 1;

    logic                         start;
    logic                         busy;
    logic                         done;
    logic                         cfg_err;
    logic [DIM_W-1:0]             input_width;
    logic [DIM_W-1:0]             input_height;
    logic [KS_W-1:0]              kernel_size;
    logic [CH_W-1:0]              in_channels;
    logic [1:0]                   stride;
    logic signed [DATA_WIDTH-1:0] bias;
    logic signed [DATA_WIDTH-1:0] local_kernel [MAX_IN_CH][MAX_KERNEL_DIM][MAX_KERNEL_DIM];
    logic signed [DATA_WIDTH-1:0] local_activation_in [MAX_IN_CH][MAX_INPUT_DIM][MAX_INPUT_DIM];
    logic signed [DATA_WIDTH-1:0] local_activation_out [MAX_INPUT_DIM][MAX_INPUT_DIM];

    modport master (
        output start, input_width, input_height, kernel_size, in_channels, stride, bias,
               local_kernel, local_activation_in,
        input  busy, done, cfg_err, local_activation_out
    );

    modport slave (
        input  start, input_width, input_height, kernel_size, in_channels, stride, bias,
               local_kernel, local_activation_in,
        output busy, done, cfg_err, local_activation_out
    );
endinterface

// File: rtl/conv_out_stage.sv
// Combinational bias add, signed saturation and optional ReLU for one output pixel.
// Define CONV_RELU_EN to clamp negative results to zero.
module conv_out_stage
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_W      = 40
) (
    input  logic signed [ACC_W-1:0]      acc_i,
    input  logic signed [DATA_WIDTH-1:0] bias_i,
    output logic signed [DATA_WIDTH-1:0] data_o
);
    logic signed [63:0] sum;
    logic signed [63:0] sat;

    always_comb begin
        sum = 64'(acc_i) + 64'(bias_i);
        sat = sat_to_data(sum, DATA_WIDTH);
`ifdef CONV_RELU_EN
        data_o = (sat < 64'sd0) ? '0 : DATA_WIDTH'(sat);
`else
        data_o = DATA_WIDTH'(sat);
`endif
    end
endmodule

// File: rtl/conv_multich_nmcu.sv
// Multi-channel strided 2-D convolution: one MAC per cycle, one WRITE per output pixel.
// ReLU on the written result is enabled by defining CONV_RELU_EN.
module conv_multich_nmcu
    import conv_pkg::*;
#(
    parameter int MAX_INPUT_DIM  = 15,
    parameter int MAX_KERNEL_DIM = 7,
    parameter int MAX_IN_CH      = 4,
    parameter int DATA_WIDTH     = 16
) (
    input logic               clk,
    input logic               rst_n,
    conv_multich_nmcu_if.slave bus
);
    localparam int DIM_W = $clog2(MAX_INPUT_DIM) + 1;
    localparam int KS_W  = $clog2(MAX_KERNEL_DIM) + 1;
    localparam int CH_W  = $clog2(MAX_IN_CH) + 1;
    localparam int IDX_W = (MAX_INPUT_DIM > 1) ? $clog2(MAX_INPUT_DIM) : 1;
    localparam int KI_W  = (MAX_KERNEL_DIM > 1) ? $clog2(MAX_KERNEL_DIM) : 1;
    localparam int CI_W  = (MAX_IN_CH > 1) ? $clog2(MAX_IN_CH) : 1;
    localparam int ACC_W = acc_width(DATA_WIDTH, MAX_IN_CH, MAX_KERNEL_DIM);

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            x_q, x_d, y_q, y_d;
    logic [KI_W-1:0]             i_q, i_d, j_q, j_d;
    logic [CI_W-1:0]             c_q, c_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic                        cfg_err_q, cfg_err_d;
    logic signed [DATA_WIDTH-1:0] out_q [MAX_INPUT_DIM][MAX_INPUT_DIM];

    logic                        cfg_valid, s2, wr_en;
    logic                        j_end, i_end, c_end, x_end, y_end;
    logic [DIM_W-1:0]            diff_w, diff_h;
    logic [IDX_W-1:0]            row_idx, col_idx;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0] wr_data;

    assign cfg_valid = (bus.kernel_size != '0)
                    && (bus.kernel_size <= KS_W'(MAX_KERNEL_DIM))
                    && (DIM_W'(bus.kernel_size) <= bus.input_width)
                    && (DIM_W'(bus.kernel_size) <= bus.input_height)
                    && (bus.input_width <= DIM_W'(MAX_INPUT_DIM))
                    && (bus.input_height <= DIM_W'(MAX_INPUT_DIM))
                    && (bus.in_channels != '0)
                    && (bus.in_channels <= CH_W'(MAX_IN_CH))
                    && ((bus.stride == STRIDE_ONE) || (bus.stride == STRIDE_TWO));

    assign s2     = (bus.stride == STRIDE_TWO);
    assign diff_w = bus.input_width - DIM_W'(bus.kernel_size);
    assign diff_h = bus.input_height - DIM_W'(bus.kernel_size);
    assign x_end  = (DIM_W'(x_q) == (s2 ? (diff_w >> 1) : diff_w));
    assign y_end  = (DIM_W'(y_q) == (s2 ? (diff_h >> 1) : diff_h));
    assign j_end  = (KS_W'(j_q) == bus.kernel_size - KS_W'(1));
    assign i_end  = (KS_W'(i_q) == bus.kernel_size - KS_W'(1));
    assign c_end  = (CH_W'(c_q) == bus.in_channels - CH_W'(1));

    // Sums never exceed MAX_INPUT_DIM-1 for a valid config, so truncation is exact.
    assign row_idx = IDX_W'((s2 ? {y_q, 1'b0} : {1'b0, y_q}) + (IDX_W + 1)'(i_q));
    assign col_idx = IDX_W'((s2 ? {x_q, 1'b0} : {1'b0, x_q}) + (IDX_W + 1)'(j_q));
    assign prod    = bus.local_activation_in[c_q][row_idx][col_idx] * bus.local_kernel[c_q][i_q][j_q];

    conv_out_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_W     (ACC_W)
    ) u_out_stage (
        .acc_i (acc_q),
        .bias_i(bus.bias),
        .data_o(wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            c_q       <= '0;
            acc_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            i_q       <= i_d;
            j_q       <= j_d;
            c_q       <= c_d;
            acc_q     <= acc_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        i_d       = i_q;
        j_d       = j_q;
        c_d       = c_q;
        acc_d     = acc_q;
        cfg_err_d = 1'b0;
        wr_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (cfg_valid) begin
                        x_d     = '0;
                        y_d     = '0;
                        i_d     = '0;
                        j_d     = '0;
                        c_d     = '0;
                        acc_d   = '0;
                        state_d = MAC;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                // j fastest, then i, then channel.
                if (!j_end) begin
                    j_d = j_q + KI_W'(1);
                end else begin
                    j_d = '0;
                    if (!i_end) begin
                        i_d = i_q + KI_W'(1);
                    end else begin
                        i_d = '0;
                        if (!c_end) begin
                            c_d = c_q + CI_W'(1);
                        end else begin
                            c_d     = '0;
                            state_d = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                wr_en   = 1'b1;
                acc_d   = '0;
                state_d = MAC;
                if (!x_end) begin
                    x_d = x_q + IDX_W'(1);
                end else begin
                    x_d = '0;
                    if (!y_end) begin
                        y_d = y_q + IDX_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < MAX_INPUT_DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < MAX_INPUT_DIM; gj++) begin : g_col
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q[gi][gj] <= '0;
                end else if (wr_en && (y_q == IDX_W'(gi)) && (x_q == IDX_W'(gj))) begin
                    out_q[gi][gj] <= wr_data;
                end
            end
            assign bus.local_activation_out[gi][gj] = out_q[gi][gj];
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_conv_multich_nmcu.sv
// Scoreboard bench for conv_multich_nmcu: stimulus pushes expected events, a monitor checks them.
module tb_conv_multich_nmcu;
    localparam int MID = 15;
    localparam int MKD = 7;
    localparam int MCH = 4;
    localparam int DW  = 16;
    localparam int IMG_BITS = MID * MID * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    int act [MCH][MID][MID];
    int ker [MCH][MKD][MKD];
    int mdl [MID][MID];

    bit                  exp_err_q   [$];
    int                  exp_lat_q   [$];
    int                  exp_start_q [$];
    logic [IMG_BITS-1:0] exp_img_q   [$];

    conv_multich_nmcu_if #(.MAX_INPUT_DIM(MID), .MAX_KERNEL_DIM(MKD),
                           .MAX_IN_CH(MCH), .DATA_WIDTH(DW)) bus ();

    conv_multich_nmcu #(.MAX_INPUT_DIM(MID), .MAX_KERNEL_DIM(MKD),
                        .MAX_IN_CH(MCH), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endfunction

    function automatic logic [IMG_BITS-1:0] pack_model();
        logic [IMG_BITS-1:0] img;
        img = '0;
        for (int r = 0; r < MID; r++)
            for (int c = 0; c < MID; c++)
                img[(r*MID+c)*DW +: DW] = DW'(mdl[r][c]);
        return img;
    endfunction

    // Monitor: every completion or rejection event consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (bus.done === 1'b1 || bus.cfg_err === 1'b1)) begin
            if (exp_err_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event got done=%0d cfg_err=%0d want none", bus.done, bus.cfg_err);
            end else begin
                bit                  e_err;
                int                  e_lat, e_start, nbad, first_r, first_c, got_v, want_v;
                logic [IMG_BITS-1:0] e_img;
                e_err   = exp_err_q.pop_front();
                e_lat   = exp_lat_q.pop_front();
                e_start = exp_start_q.pop_front();
                e_img   = exp_img_q.pop_front();
                check("evt_cfg_err", int'(bus.cfg_err), int'(e_err));
                check("evt_done", int'(bus.done), int'(!e_err));
                check("evt_busy", int'(bus.busy), int'(!e_err));
                check("evt_latency", cyc - e_start, e_lat);
                nbad = 0; first_r = 0; first_c = 0; got_v = 0; want_v = 0;
                for (int r = 0; r < MID; r++)
                    for (int c = 0; c < MID; c++)
                        if (int'(bus.local_activation_out[r][c]) != int'($signed(e_img[(r*MID+c)*DW +: DW]))) begin
                            if (nbad == 0) begin
                                first_r = r; first_c = c;
                                got_v   = int'(bus.local_activation_out[r][c]);
                                want_v  = int'($signed(e_img[(r*MID+c)*DW +: DW]));
                            end
                            nbad++;
                        end
                total++;
                if (nbad != 0) begin
                    bad++;
                    $display("FAIL out_image %0d wrong entries, first [%0d][%0d] got=%0d want=%0d",
                             nbad, first_r, first_c, got_v, want_v);
                end
                $display("txn %s lat=%0d", e_err ? "cfg_err" : "done", cyc - e_start);
            end
        end
    end

    task automatic fill_random(input int lo, input int hi);
        for (int c = 0; c < MCH; c++) begin
            for (int r = 0; r < MID; r++)
                for (int k = 0; k < MID; k++)
                    act[c][r][k] = lo + int'($urandom_range(0, hi - lo));
            for (int r = 0; r < MKD; r++)
                for (int k = 0; k < MKD; k++)
                    ker[c][r][k] = lo + int'($urandom_range(0, hi - lo));
        end
    endtask

    task automatic fill_const(input int ch, input int a, input int kv);
        for (int r = 0; r < MID; r++)
            for (int k = 0; k < MID; k++)
                act[ch][r][k] = a;
        for (int r = 0; r < MKD; r++)
            for (int k = 0; k < MKD; k++)
                ker[ch][r][k] = kv;
    endtask

    task automatic set_cfg(input int w, input int h, input int k, input int c, input int s, input int b);
        bus.input_width  = 5'(w);
        bus.input_height = 5'(h);
        bus.kernel_size  = 4'(k);
        bus.in_channels  = 3'(c);
        bus.stride       = 2'(s);
        bus.bias         = 16'(b);
        for (int ch = 0; ch < MCH; ch++) begin
            for (int r = 0; r < MID; r++)
                for (int x = 0; x < MID; x++)
                    bus.local_activation_in[ch][r][x] = 16'(act[ch][r][x]);
            for (int r = 0; r < MKD; r++)
                for (int x = 0; x < MKD; x++)
                    bus.local_kernel[ch][r][x] = 16'(ker[ch][r][x]);
        end
    endtask

    // Reference: plain nested-sum convolution over the output map.
    task automatic run_op(input int w, input int h, input int k, input int c, input int s, input int b);
        bit     valid;
        int     ow, oh;
        longint sum;
        set_cfg(w, h, k, c, s, b);
        valid = (k >= 1) && (k <= MKD) && (k <= w) && (k <= h) && (w <= MID) && (h <= MID)
             && (c >= 1) && (c <= MCH) && (s == 1 || s == 2);
        ow = 0; oh = 0;
        if (valid) begin
            ow = (w - k) / s + 1;
            oh = (h - k) / s + 1;
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++) begin
                    sum = b;
                    for (int ch = 0; ch < c; ch++)
                        for (int i = 0; i < k; i++)
                            for (int j = 0; j < k; j++)
                                sum += longint'(act[ch][oy*s+i][ox*s+j]) * longint'(ker[ch][i][j]);
                    if (sum > 32767) sum = 32767;
                    if (sum < -32768) sum = -32768;
`ifdef CONV_RELU_EN
                    if (sum < 0) sum = 0;
`endif
                    mdl[oy][ox] = int'(sum);
                end
        end
        exp_err_q.push_back(!valid);
        exp_lat_q.push_back(valid ? ow * oh * (c * k * k + 1) : 0);
        exp_start_q.push_back(cyc + 1);
        exp_img_q.push_back(pack_model());
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 0; n < 20000 && exp_err_q.size() != 0; n++) begin
            @(negedge clk);
            #1;
        end
        check("scoreboard_drained", exp_err_q.size(), 0);
        exp_err_q.delete(); exp_lat_q.delete(); exp_start_q.delete(); exp_img_q.delete();
        @(negedge clk);
        #1;
        check("done_one_cycle", int'(bus.done), 0);
        check("cfg_err_one_cycle", int'(bus.cfg_err), 0);
        check("busy_after_event", int'(bus.busy), 0);
    endtask

    initial begin
        int nz;
        bus.start = 1'b0;
        for (int r = 0; r < MID; r++)
            for (int c = 0; c < MID; c++)
                mdl[r][c] = 0;
        fill_random(-50, 50);
        set_cfg(3, 3, 2, 1, 1, 0);
        repeat (2) @(negedge clk);
        #1;
        nz = 0;
        for (int r = 0; r < MID; r++)
            for (int c = 0; c < MID; c++)
                if (bus.local_activation_out[r][c] != 0) nz++;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_cfg_err", int'(bus.cfg_err), 0);
        check("reset_outputs_nonzero", nz, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized configurations, occasionally full-scale to exercise saturation.
        for (int t = 0; t < 12; t++) begin
            int w, h, k, c, s, kmax;
            w = int'($urandom_range(1, 7));
            h = int'($urandom_range(1, 7));
            kmax = (w < h) ? w : h;
            if (kmax > 3) kmax = 3;
            k = int'($urandom_range(1, kmax));
            c = int'($urandom_range(1, 4));
            s = int'($urandom_range(1, 2));
            if (t % 4 == 3) fill_random(-32768, 32767);
            else            fill_random(-60, 60);
            run_op(w, h, k, c, s, int'($urandom_range(0, 400)) - 200);
        end

        // Single channel, stride 1, 1..9 input.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                act[0][r][c] = r * 3 + c + 1;
        for (int r = 0; r < MKD; r++)
            for (int c = 0; c < MKD; c++)
                ker[0][r][c] = 1;
        run_op(3, 3, 2, 1, 1, 0);
        check("tp1_out00", int'(bus.local_activation_out[0][0]), 12);
        check("tp1_out01", int'(bus.local_activation_out[0][1]), 16);
        check("tp1_out10", int'(bus.local_activation_out[1][0]), 24);
        check("tp1_out11", int'(bus.local_activation_out[1][1]), 28);

        fill_const(0, 1, 1);
        fill_const(1, 2, 3);
        run_op(2, 2, 2, 2, 1, -3);
        check("tp2_out00", int'(bus.local_activation_out[0][0]), 25);

        fill_const(0, 1, 1);
        run_op(5, 5, 3, 1, 2, 0);
        check("tp3_out00", int'(bus.local_activation_out[0][0]), 9);
        check("tp3_out11", int'(bus.local_activation_out[1][1]), 9);

        fill_const(0, 32767, 32767);
        run_op(2, 2, 2, 1, 1, 0);
        check("sat_pos", int'(bus.local_activation_out[0][0]), 32767);
        fill_const(0, -32768, 32767);
        run_op(2, 2, 2, 1, 1, 0);
`ifdef CONV_RELU_EN
        check("sat_neg", int'(bus.local_activation_out[0][0]), 0);
`else
        check("sat_neg", int'(bus.local_activation_out[0][0]), -32768);
`endif
        fill_const(0, 1, -1);
        run_op(2, 2, 2, 1, 1, 0);
`ifdef CONV_RELU_EN
        check("relu_neg", int'(bus.local_activation_out[0][0]), 0);
`else
        check("relu_neg", int'(bus.local_activation_out[0][0]), -4);
`endif

        run_op(3, 3, 0, 1, 1, 0);
        run_op(3, 3, 4, 1, 1, 0);
        run_op(3, 3, 2, 1, 3, 0);

        // Asynchronous reset during the MAC phase of output pixel (1,0).
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                act[0][r][c] = r * 3 + c + 1;
        for (int r = 0; r < MKD; r++)
            for (int c = 0; c < MKD; c++)
                ker[0][r][c] = 1;
        set_cfg(3, 3, 2, 1, 1, 0);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_reset_busy", int'(bus.busy), 1);
        check("pre_reset_pix", int'(bus.local_activation_out[0][0]), 12);
        #1 rst_n = 1'b0;
        #1;
        nz = 0;
        for (int r = 0; r < MID; r++)
            for (int c = 0; c < MID; c++)
                if (bus.local_activation_out[r][c] != 0) nz++;
        check("midrun_reset_busy", int'(bus.busy), 0);
        check("midrun_reset_done", int'(bus.done), 0);
        check("midrun_reset_outputs_nonzero", nz, 0);
        for (int r = 0; r < MID; r++)
            for (int c = 0; c < MID; c++)
                mdl[r][c] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(3, 3, 2, 1, 1, 0);
        check("post_reset_out11", int'(bus.local_activation_out[1][1]), 28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_multich_nmcu.md
# conv_multich_nmcu

Multi-channel, strided 2-D convolution engine for the near-memory compute unit. It is the parametrised successor to the single-channel conv core. It accumulates one output feature map over `in_channels` input planes, then applies stride, bias, signed saturation and optional ReLU. It sits between the NMCU's local activation/kernel buffers and its output buffer, and is sequenced by the NMCU controller through a start/busy/done handshake.

## Interface
- `MAX_INPUT_DIM`, 15: maximum input plane width/height.
- `MAX_KERNEL_DIM`, 7: maximum kernel side.
- `MAX_IN_CH`, 4: maximum input channel count.
- `DATA_WIDTH`, 16: signed activation/kernel/bias/output width.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `cfg_err` out 1: one-cycle pulse on rejected start.
- `input_width`, `input_height` in $clog2(MAX_INPUT_DIM)+1: plane dimensions.
- `kernel_size` in $clog2(MAX_KERNEL_DIM)+1: K.
- `in_channels` in $clog2(MAX_IN_CH)+1: C.
- `stride` in 2: legal values are 1 and 2.
- `bias` in DATA_WIDTH: signed, added once per output pixel.
- `local_kernel` in [MAX_IN_CH][MAX_KERNEL_DIM][MAX_KERNEL_DIM]×DATA_WIDTH: signed weights.
- `local_activation_in` in [MAX_IN_CH][MAX_INPUT_DIM][MAX_INPUT_DIM]×DATA_WIDTH: signed activations.
- `local_activation_out` out [MAX_INPUT_DIM][MAX_INPUT_DIM]×DATA_WIDTH: signed results.

## Operation
- Output dimensions: OW = (W−K)/S+1 and OH = (H−K)/S+1, using floor division.
- Valid config requires all of: 1≤K≤MAX_KERNEL_DIM; K≤W; K≤H; 1≤C≤MAX_IN_CH; S∈{1,2}.
- States:
  - IDLE: on `start` with a valid config, clear the accumulator, x, y, c, i, j and go to MAC. On `start` with an invalid config, pulse `cfg_err` and stay in IDLE.
  - MAC: each cycle, acc += in[c][y·S+i][x·S+j]·k[c][i][j]. Iteration order is j fastest, then i, then c. After the (C,K,K) term, go to WRITE.
  - WRITE: out[y][x] = relu?(sat(acc+bias)). Clear acc. Advance x, wrapping to 0 and incrementing y. Return to MAC, or after the last pixel go to DONE.
  - DONE: `done`=1 for this cycle only, then IDLE.
- Arithmetic:
  - Products are 2·DATA_WIDTH signed.
  - Accumulator is ACC_WIDTH = 2·DATA_WIDTH + $clog2(MAX_IN_CH·MAX_KERNEL_DIM²) signed, so it never overflows.
  - Saturation clamps to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Output entries outside OH×OW keep their previous values.
- `start` while busy is ignored.
- Config and input arrays must be held stable while `busy`. Behaviour is undefined if they are not.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `cfg_err`=0; all counters and acc=0; every `local_activation_out` entry 0.
- Latency from the accepting `start` edge to `done` high is OW·OH·(C·K²+1) cycles. `busy` falls one cycle after `done`.
- A rejected start produces `cfg_err` high in the next cycle, and `busy` stays 0.
- Each output pixel becomes visible the cycle after its WRITE. All pixels are final when `done` is high.
- Reset is asserted asynchronously at any time, including mid-MAC. It forces the reset values immediately. The next start after reset runs from scratch.
- Back-to-back operation: `start` is accepted on the first IDLE cycle after DONE.

## Configuration
- `CONV_RELU_EN` defined: WRITE stores max(0, sat(acc+bias)).
- `CONV_RELU_EN` undefined: WRITE stores sat(acc+bias) unchanged, including negative values.

## Structure
- Package `conv_pkg`:
  - `state_t` with states IDLE, MAC, WRITE, DONE.
  - Stride legality constants.
  - ACC_WIDTH derivation function.
  - `sat_to_data` function.
- Sub-module `conv_out_stage`: combinational bias add, saturation and ReLU. The `CONV_RELU_EN` branch lives here. It is instantiated once, and WRITE uses its output.

## Test plan
- Single channel, stride 1: C=1, S=1, W=H=3, input 1..9 row-major, K=2, kernel all 1, bias 0 → out [[12,16],[24,28]]; `done` 20 cycles after start.
- Two channels with bias: C=2, W=H=2, K=2.
  - ch0: input all 1, kernel all 1.
  - ch1: input all 2, kernel all 3.
  - bias −3 → out[0][0]=25; `done` after 9 cycles.
- Stride 2: S=2, 5×5 input all 1, K=3, kernel all 1, C=1 → 2×2 output all 9; `done` after 40 cycles; out[2][*] untouched.
- Saturation and ReLU: DATA_WIDTH=8, K=2.
  - Input 127, kernel 127 → 127.
  - Kernel −1, input 1, bias 0 → 0 with `CONV_RELU_EN`, −4 without.
- Invalid config: K=0, then K=4 with W=3, then S=3 → `cfg_err` one-cycle pulse each time; `busy` and `done` stay 0; outputs unchanged.
- Reset mid-operation: `rst_n` low during MAC of pixel (1,0) → `busy`, `done` and all outputs 0 immediately; a subsequent start completes with correct results and the full latency.
